// File: rtl/argmax_classifier_pkg.sv
// Shared widths, score type and FSM encoding for the MNIST argmax stage.
// Pure declarations, no latency, no flow control.
// Also used by upstream FC logic so the score format stays in one place.
package argmax_classifier_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_CLASSES = 10;
    localparam int CLS_W       = $clog2(NUM_CLASSES);

    typedef logic signed [DATA_WIDTH-1:0] score_t;
    typedef logic [CLS_W-1:0]             cls_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam score_t SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam cls_t   CLS_COUNT = CLS_W'(NUM_CLASSES);

    // One extra bit so top1 - top2 can span the full signed range without wrapping.
    function automatic logic [DATA_WIDTH:0] score_diff(input score_t a, input score_t b);
        return {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    endfunction

endpackage

// File: rtl/argmax_classifier_top2_tracker.sv
// Running top-1 / top-2 tracker over a serial score stream; ties keep the earlier index.
// Latency: results visible the cycle after en.
// Backpressure: none, accepts a score on every en cycle.
module argmax_classifier_top2_tracker
    import argmax_classifier_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   en,
    input  logic   first,
    input  score_t score,
    input  cls_t   pos,
    output score_t top1,
    output score_t top2,
    output cls_t   idx
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top1 <= '0;
            top2 <= '0;
            idx  <= '0;
        end else if (clear) begin
            top1 <= '0;
            top2 <= '0;
            idx  <= '0;
        end else if (en) begin
            if (first) begin
                top1 <= score;
                top2 <= SCORE_MIN;
                idx  <= '0;
            end else if (score > top1) begin
                top2 <= top1;
                top1 <= score;
                idx  <= pos;
            end else if (score > top2) begin
                top2 <= score;
            end
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Argmax over one frame of class scores: winning index, top score, top1-top2 margin, error flag.
// Latency: class_valid two cycles after frame_done; debug readback one cycle.
// Backpressure: none; excess scores are dropped and flagged, start aborts any frame in flight.
module argmax_classifier
    import argmax_classifier_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] score_in,
    input  logic                  score_valid,
    input  logic                  frame_done,
    output logic [CLS_W-1:0]      class_out,
    output logic [DATA_WIDTH-1:0] top_score,
    output logic [DATA_WIDTH:0]   margin,
    output logic                  class_valid,
    output logic                  frame_err,
    output logic                  busy,
    input  logic [CLS_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    state_t              state;
    state_t              state_nxt;
    cls_t                cnt;
    logic                ovf;
    logic                accept;
    score_t              top1;
    score_t              top2;
    cls_t                idx;
    logic [DATA_WIDTH:0] margin_calc;
    score_t              score_mem [NUM_CLASSES];

    assign accept      = (state == ST_COLLECT) && !start && score_valid && (cnt < CLS_COUNT);
    assign busy        = (state == ST_COLLECT) || (state == ST_RESOLVE);
    assign margin_calc = score_diff(top1, top2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start wins from every state: it arms a fresh frame and discards whatever was in flight.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_COLLECT;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_IDLE;
                ST_COLLECT: if (frame_done) state_nxt = ST_RESOLVE;
                ST_RESOLVE: state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (state == ST_COLLECT && score_valid) begin
            if (cnt < CLS_COUNT) begin
                cnt <= cnt + CLS_W'(1);
            end else begin
                ovf <= 1'b1;
            end
        end
    end

    argmax_classifier_top2_tracker u_tracker (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (accept),
        .first (cnt == '0),
        .score (score_t'(score_in)),
        .pos   (cnt),
        .top1  (top1),
        .top2  (top2),
        .idx   (idx)
    );

    // Results are captured leaving RESOLVE so class_valid is high exactly while in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_out   <= '0;
            top_score   <= '0;
            margin      <= '0;
            frame_err   <= 1'b0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (state == ST_RESOLVE && !start) begin
                class_out   <= idx;
                top_score   <= top1;
                margin      <= margin_calc;
                frame_err   <= (cnt != CLS_COUNT) || ovf;
                class_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            score_mem[cnt] <= score_t'(score_in);
        end
    end

    // Registered read sees the pre-write value on a same-cycle write/read collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_addr < CLS_COUNT) begin
            rd_data <= score_mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: directed vector table, abort/reset sequences, random frames vs a model.
module tb_argmax_classifier;
    import argmax_classifier_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [DATA_WIDTH-1:0] score_in;
    logic                  score_valid;
    logic                  frame_done;
    logic [CLS_W-1:0]      class_out;
    logic [DATA_WIDTH-1:0] top_score;
    logic [DATA_WIDTH:0]   margin;
    logic                  class_valid;
    logic                  frame_err;
    logic                  busy;
    logic [CLS_W-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    argmax_classifier dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .score_in    (score_in),
        .score_valid (score_valid),
        .frame_done  (frame_done),
        .class_out   (class_out),
        .top_score   (top_score),
        .margin      (margin),
        .class_valid (class_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int vcount = 0;

    always @(posedge clk) if (class_valid) vcount++;

    typedef struct {
        int              n;
        logic [0:11][15:0] s;
        int              cls;
        int              top;
        int              mg;
        int              err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_scores(input int s[$], input bit fd_last);
        for (int i = 0; i < s.size(); i++) begin
            score_in    = 16'(s[i]);
            score_valid = 1'b1;
            frame_done  = fd_last && (i == s.size() - 1);
            @(negedge clk);
        end
        score_valid = 1'b0;
        frame_done  = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    // Called one half-cycle after the edge that sampled frame_done.
    task automatic expect_result(input string nm, input int cls, input int top, input int mg, input int err);
        chk({nm, "_valid_early"}, int'(class_valid), 0);
        chk({nm, "_busy_resolve"}, int'(busy), 1);
        @(negedge clk);
        chk({nm, "_valid"}, int'(class_valid), 1);
        chk({nm, "_class"}, int'(class_out), cls);
        chk({nm, "_top"}, int'($signed(top_score)), top);
        chk({nm, "_margin"}, int'(margin), mg);
        chk({nm, "_err"}, int'(frame_err), err);
        @(negedge clk);
        chk({nm, "_valid_once"}, int'(class_valid), 0);
        chk({nm, "_class_hold"}, int'(class_out), cls);
    endtask

    task automatic readback(input string nm, input int exp_vals[$]);
        for (int a = 0; a < exp_vals.size(); a++) begin
            rd_addr = CLS_W'(a);
            @(negedge clk);
            chk($sformatf("%s_rd%0d", nm, a), int'($signed(rd_data)), exp_vals[a]);
        end
        rd_addr = CLS_W'(12);
        @(negedge clk);
        chk({nm, "_rd_oob"}, int'(rd_data), 0);
        rd_addr = '0;
    endtask

    // Argmax with lowest-index tie break, runner-up as the max of everything but the winner.
    task automatic ref_model(input int s[$], output int cls, output int top, output int mg, output int err);
        int acc[$];
        int second;
        for (int i = 0; i < s.size() && i < NUM_CLASSES; i++) acc.push_back(s[i]);
        err = (s.size() != NUM_CLASSES) ? 1 : 0;
        cls = 0; top = 0; mg = 0;
        if (acc.size() > 0) begin
            top = acc[0];
            for (int i = 1; i < acc.size(); i++) begin
                if (acc[i] > top) begin
                    top = acc[i];
                    cls = i;
                end
            end
            second = -32768;
            for (int i = 0; i < acc.size(); i++) begin
                if (i != cls && acc[i] > second) second = acc[i];
            end
            mg = top - second;
        end
    endtask

    function automatic int rand_score();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 3));
            1: return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int q[$];
        int first10[$];
        int cls, top, mg, err, v0, n;
        bit sep;

        vecs[0] = '{10, {16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd99, 16'sd0, -16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0, 16'sd0}, 2, 100, 1, 0};
        vecs[1] = '{10, {16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, 3, 100, 0, 0};
        vecs[2] = '{10, {12{16'h8000}}, 0, -32768, 0, 0};
        vecs[3] = '{10, {16'h7FFF, {11{16'h8000}}}, 0, 32767, 65535, 0};
        vecs[4] = '{6, {16'sd1, 16'sd2, 16'sd9, 16'sd3, 16'sd9, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0}, 2, 9, 0, 1};
        vecs[5] = '{12, {16'sd3, 16'sd1, 16'sd4, 16'sd1, 16'sd5, 16'sd9, 16'sd2, 16'sd6, 16'sd5, 16'sd3, 16'sd50, 16'sd60}, 5, 9, 3, 1};
        vecs[6] = '{0, {12{16'sd0}}, 0, 0, 0, 1};
        vecs[7] = '{1, {16'sd100, {11{16'sd0}}}, 0, 100, 32868, 1};

        reset = 1'b1; start = 1'b0; score_in = '0; score_valid = 1'b0; frame_done = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_class", int'(class_out), 0);
        chk("rst_top", int'(top_score), 0);
        chk("rst_margin", int'(margin), 0);
        chk("rst_valid", int'(class_valid), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd", int'(rd_data), 0);
        reset = 1'b0;
        @(negedge clk);

        // Scores and frame_done while idle must be ignored.
        v0 = vcount;
        score_in = 16'd77; score_valid = 1'b1; frame_done = 1'b1;
        repeat (2) @(negedge clk);
        score_valid = 1'b0; frame_done = 1'b0;
        chk("idle_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk("idle_no_valid", vcount - v0, 0);

        for (int k = 0; k < 8; k++) begin
            q = {};
            for (int i = 0; i < vecs[k].n; i++) q.push_back(int'($signed(vecs[k].s[i])));
            do_start();
            chk($sformatf("v%0d_busy_collect", k), int'(busy), 1);
            send_scores(q, vecs[k].n > 0);
            if (vecs[k].n == 0) pulse_fd();
            expect_result($sformatf("v%0d", k), vecs[k].cls, vecs[k].top, vecs[k].mg, vecs[k].err);
            if (k == 5) begin
                first10 = q[0:9];
                readback("v5", first10);
            end
        end

        // Reset in the middle of collection: outputs clear, no result for the aborted frame.
        do_start();
        send_scores('{11, 22, 33, 44}, 1'b0);
        v0 = vcount;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_class", int'(class_out), 0);
        chk("mid_rst_top", int'(top_score), 0);
        chk("mid_rst_margin", int'(margin), 0);
        chk("mid_rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_valid", vcount - v0, 0);
        q = '{5, -3, 100, 7, 99, 0, -1, 2, 3, 4};
        do_start();
        send_scores(q, 1'b1);
        expect_result("after_rst", 2, 100, 1, 0);

        // Restart after five scores; only the new frame may produce a result.
        v0 = vcount;
        do_start();
        send_scores('{900, 901, 902, 903, 904}, 1'b0);
        do_start();
        q = '{-5, 12, 40, -7, 40, 3, 39, 0, 1, 2};
        send_scores(q, 1'b1);
        expect_result("abort", 2, 40, 0, 0);
        chk("abort_one_valid", vcount - v0, 1);
        readback("abort", q);

        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 12);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(rand_score());
            sep = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ref_model(q, cls, top, mg, err);
            do_start();
            send_scores(q, !sep);
            if (sep) pulse_fd();
            expect_result($sformatf("rnd%0d", r), cls, top, mg, err);
            if (n >= NUM_CLASSES) begin
                first10 = q[0:9];
                readback($sformatf("rnd%0d", r), first10);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
